// File: rtl/vx_issue_sched.sv
// Per-core warp issue scheduler: picks one eligible warp per cycle (aging override, then
// round-robin) into a registered issue slot, and counts cycles lost to no eligible warp.
module vx_issue_sched #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned NUM_EX        = 5,
  parameter int unsigned EX_BITS       = 3,
  parameter int unsigned AGE_MAX       = 15,
  parameter int unsigned PERF_CTR_BITS = 44,
  localparam int unsigned WidBits      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int unsigned AgeBits      = $clog2(AGE_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         warp_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0] warp_ex_type,
  input  logic [NUM_WARPS-1:0]         warp_sb_ready,
  input  logic [NUM_EX-1:0]            ex_ready,
  output logic [NUM_WARPS-1:0]         warp_pop,
  output logic                         issue_valid,
  output logic [WidBits-1:0]           issue_wid,
  input  logic                         issue_ready,
  output logic [PERF_CTR_BITS-1:0]     stall_cnt
);

  logic                     issue_valid_q;
  logic [WidBits-1:0]       issue_wid_q;
  logic [WidBits-1:0]       rr_q;
  logic [AgeBits-1:0]       age_q [NUM_WARPS];
  logic [PERF_CTR_BITS-1:0] stall_q;

  logic [NUM_WARPS-1:0] ex_ok;
  logic [NUM_WARPS-1:0] elig;
  logic                 load;
  logic                 grant_valid;
  logic [WidBits-1:0]   grant_id;

  // An ex_type with no matching unit never sets ex_ok, so the warp stays ineligible.
  always_comb begin
    ex_ok = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      for (int unsigned e = 0; e < NUM_EX; e++) begin
        if (warp_ex_type[w*EX_BITS +: EX_BITS] == EX_BITS'(e)) ex_ok[w] = ex_ready[e];
      end
    end
  end

  assign elig        = warp_valid & warp_sb_ready & ex_ok;
  assign load        = !issue_valid_q || issue_ready;
  assign grant_valid = load && (elig != '0);

  always_comb begin
    logic        hit;
    int unsigned idx;
    hit      = 1'b0;
    idx      = 0;
    grant_id = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (!hit && elig[w] && age_q[w] == AgeBits'(AGE_MAX)) begin
        hit      = 1'b1;
        grant_id = WidBits'(w);
      end
    end
    for (int unsigned k = 0; k < NUM_WARPS; k++) begin
      idx = (int'(rr_q) + k) % NUM_WARPS;
      if (!hit && elig[idx]) begin
        hit      = 1'b1;
        grant_id = WidBits'(idx);
      end
    end
  end

  // Gated by reset so the ibuffer never pops a head that the dropped slot would lose.
  assign warp_pop = (grant_valid && reset) ? (NUM_WARPS'(1) << grant_id) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      rr_q          <= '0;
      stall_q       <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) age_q[w] <= '0;
    end else begin
      if (grant_valid) begin
        issue_valid_q <= 1'b1;
        issue_wid_q   <= grant_id;
        rr_q          <= WidBits'((int'(grant_id) + 1) % NUM_WARPS);
      end else if (load) begin
        issue_valid_q <= 1'b0;
      end
      if (load && (elig == '0) && (warp_valid != '0)) begin
        stall_q <= stall_q + PERF_CTR_BITS'(1);
      end
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if ((grant_valid && grant_id == WidBits'(w)) || !elig[w]) begin
          age_q[w] <= '0;
        end else if (grant_valid && age_q[w] != AgeBits'(AGE_MAX)) begin
          age_q[w] <= age_q[w] + AgeBits'(1);
        end
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_wid   = issue_wid_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_vx_issue_sched.sv
// Bench for vx_issue_sched: directed scenarios plus random traffic, checked against a
// cycle-level model of the scheduling rules, on a default instance and a short-AGE_MAX one.
module tb_vx_issue_sched;

  localparam int NW = 4;
  localparam int NE = 5;
  localparam int EB = 3;
  localparam int PB = 44;
  // With round-robin alone a warp waits at most NW-1 grants, so only a small AGE_MAX
  // lets the aging override change the outcome.
  localparam int AGE_FAST = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NW-1:0]  warp_valid, warp_sb_ready;
  logic [NW*EB-1:0] warp_ex_type;
  logic [NE-1:0]  ex_ready;
  logic           issue_ready;
  logic [NW-1:0]  pop0, pop1;
  logic           iv0, iv1;
  logic [1:0]     wid0, wid1;
  logic [PB-1:0]  st0, st1;

  vx_issue_sched dut (
    .clk(clk), .reset(reset), .warp_valid(warp_valid), .warp_ex_type(warp_ex_type),
    .warp_sb_ready(warp_sb_ready), .ex_ready(ex_ready), .warp_pop(pop0),
    .issue_valid(iv0), .issue_wid(wid0), .issue_ready(issue_ready), .stall_cnt(st0)
  );

  vx_issue_sched #(.AGE_MAX(AGE_FAST)) dut_aged (
    .clk(clk), .reset(reset), .warp_valid(warp_valid), .warp_ex_type(warp_ex_type),
    .warp_sb_ready(warp_sb_ready), .ex_ready(ex_ready), .warp_pop(pop1),
    .issue_valid(iv1), .issue_wid(wid1), .issue_ready(issue_ready), .stall_cnt(st1)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  int     age_max_m [2] = '{15, AGE_FAST};
  int     m_rr      [2];
  int     m_age     [2][NW];
  bit     m_valid   [2];
  int     m_wid     [2];
  longint m_stall   [2];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_elig(int w);
    int ex = int'(warp_ex_type[w*EB +: EB]);
    if (!warp_valid[w] || !warp_sb_ready[w] || ex >= NE) return 1'b0;
    return ex_ready[ex];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rr[i] = 0; m_valid[i] = 1'b0; m_wid[i] = 0; m_stall[i] = 0;
      for (int w = 0; w < NW; w++) m_age[i][w] = 0;
    end
  endtask

  task automatic drive(logic [NW-1:0] v, logic [NW-1:0] sb, logic [NW*EB-1:0] ext,
                       logic [NE-1:0] exr, logic ir);
    warp_valid = v; warp_sb_ready = sb; warp_ex_type = ext; ex_ready = exr; issue_ready = ir;
  endtask

  // One cycle: check warp_pop mid-cycle, advance the model, check registered outputs.
  task automatic step(int chk_pop);
    bit e [NW];
    bit any_e;
    bit load;
    int g;
    int idx;
    #1;
    any_e = 1'b0;
    for (int w = 0; w < NW; w++) begin
      e[w] = is_elig(w);
      any_e |= e[w];
    end
    for (int i = 0; i < 2; i++) begin
      load = !m_valid[i] || issue_ready;
      g = -1;
      if (load && any_e) begin
        for (int w = 0; w < NW; w++)
          if (g < 0 && e[w] && m_age[i][w] == age_max_m[i]) g = w;
        for (int k = 0; k < NW; k++) begin
          idx = (m_rr[i] + k) % NW;
          if (g < 0 && e[idx]) g = idx;
        end
      end
      check($sformatf("warp_pop[dut%0d]", i), (i == 0) ? pop0 : pop1,
            (g < 0) ? 0 : (1 << g));
      if (load && !any_e && warp_valid != 0) m_stall[i]++;
      for (int w = 0; w < NW; w++) begin
        if (w == g || !e[w]) m_age[i][w] = 0;
        else if (g >= 0 && m_age[i][w] < age_max_m[i]) m_age[i][w]++;
      end
      if (g >= 0) begin
        m_valid[i] = 1'b1; m_wid[i] = g; m_rr[i] = (g + 1) % NW;
      end else if (load) begin
        m_valid[i] = 1'b0;
      end
    end
    if (chk_pop >= 0) check("warp_pop_directed", pop0, chk_pop);
    @(posedge clk);
    #1;
    check("issue_valid[dut0]", iv0, m_valid[0]);
    check("issue_valid[dut1]", iv1, m_valid[1]);
    if (m_valid[0]) check("issue_wid[dut0]", wid0, m_wid[0]);
    if (m_valid[1]) check("issue_wid[dut1]", wid1, m_wid[1]);
    check("stall_cnt[dut0]", st0, m_stall[0] & ((64'd1 << PB) - 1));
    check("stall_cnt[dut1]", st1, m_stall[1] & ((64'd1 << PB) - 1));
  endtask

  initial begin
    logic [PB-1:0] s0;
    reset = 1'b0;
    drive(4'hf, 4'hf, '0, 5'h1f, 1'b1);
    model_reset();
    #2;
    check("reset_pop0", pop0, 0);
    check("reset_pop1", pop1, 0);
    check("reset_valid", iv0, 0);
    check("reset_wid", wid0, 0);
    check("reset_stall", st0, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // All warps eligible: plain round-robin from warp 0
    for (int i = 0; i < 8; i++) step(1 << (i % NW));

    // Rotate pointer to 2, then warps 1 and 3 compete
    drive(4'b0010, 4'hf, '0, 5'h1f, 1'b1);
    step(4'b0010);
    drive(4'b1010, 4'hf, '0, 5'h1f, 1'b1);
    step(4'b1000);
    step(4'b0010);
    step(4'b1000);

    // Load slot with warp 2, then hold for 5 cycles
    drive(4'b0100, 4'hf, '0, 5'h1f, 1'b1);
    step(4'b0100);
    drive(4'hf, 4'hf, '0, 5'h1f, 1'b0);
    s0 = st0;
    for (int i = 0; i < 5; i++) step(0);
    check("hold_wid", wid0, 2);
    check("hold_stall", st0, s0);
    issue_ready = 1'b1;
    step(4'b1000);

    // Every head targets LSU, which is busy
    drive(4'hf, 4'hf, 12'o1111, 5'b11101, 1'b1);
    s0 = st0;
    for (int i = 0; i < 10; i++) step(0);
    check("lsu_block_stall_delta", st0 - s0, 10);
    check("lsu_block_valid", iv0, 0);

    // Staggered eligibility to push ages to the override in the short-AGE_MAX instance
    drive(4'b0001, 4'hf, '0, 5'h1f, 1'b1);
    step(-1);
    drive(4'hf, 4'hf, '0, 5'h1f, 1'b1);
    for (int i = 0; i < 8; i++) step(-1);
    drive(4'b1110, 4'hf, '0, 5'h1f, 1'b1);
    step(-1);
    drive(4'hf, 4'hf, '0, 5'h1f, 1'b1);
    for (int i = 0; i < 6; i++) step(-1);

    // Random traffic, ex_type spans invalid codes 5..7
    for (int i = 0; i < 400; i++) begin
      drive(NW'($urandom), NW'($urandom | $urandom), (NW*EB)'($urandom),
            NE'($urandom | $urandom), ($urandom_range(0, 3) != 0));
      step(-1);
    end

    // Reset asserted while a slot is held
    drive(4'hf, 4'hf, '0, 5'h1f, 1'b1);
    step(-1);
    issue_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset_valid0", iv0, 0);
    check("midreset_valid1", iv1, 0);
    check("midreset_pop0", pop0, 0);
    check("midreset_pop1", pop1, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    drive(4'b0100, 4'hf, '0, 5'h1f, 1'b1);
    step(4'b0100);
    check("post_reset_wid", wid0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
